// File: rtl/row_accum_ctrl.sv
// rtl/row_accum_ctrl.sv - row reduction controller with LAT interleaved partial-sum slots
module row_accum_ctrl #(
  parameter int DATA_W = 24,
  parameter int LAT    = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              proto_err,
  output logic              busy
);

  localparam int TAG_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [TAG_W-1:0] LAST_SLOT  = TAG_W'(LAT - 1);
  localparam logic [3:0]       LAST_PHASE = 4'(LAT - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, OUTPUT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        phase;
  logic [TAG_W-1:0]  ptr, slot, slot_nxt, red_idx;
  logic [LAT-1:0]    used;
  logic [DATA_W-1:0] psum      [LAT];
  logic [DATA_W-1:0] pipe_data [LAT];
  logic [TAG_W-1:0]  pipe_tag  [LAT];
  logic [LAT-1:0]    pipe_vld;
  logic [DATA_W-1:0] total, operand_b, red_term;
  logic [CNT_W-1:0]  count;
  logic              accept, row_start, phase_end, framing_bad;

  always_comb begin
    in_ready    = (state == IDLE) || (state == ACCUM);
    accept      = in_valid && in_ready;
    row_start   = (state == IDLE);
    slot        = row_start ? '0 : ptr;
    slot_nxt    = (slot == LAST_SLOT) ? '0 : slot + TAG_W'(1);
    phase_end   = (phase == LAST_PHASE);
    red_idx     = phase[TAG_W-1:0];
    red_term    = used[red_idx] ? psum[red_idx] : '0;
    framing_bad = accept && (row_start ? !in_first : in_first);
    // A result leaving the last adder stage this cycle is newer than psum.
    operand_b = '0;
    if (!row_start) begin
      if (pipe_vld[LAT-1] && (pipe_tag[LAT-1] == slot)) begin
        operand_b = pipe_data[LAT-1];
      end else if (used[slot]) begin
        operand_b = psum[slot];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (phase_end) state_nxt = REDUCE;
      REDUCE:  if (phase_end) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    out_valid = (state == OUTPUT);
    busy      = (state != IDLE);
    out_data  = total;
    out_count = count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      ptr       <= '0;
      used      <= '0;
      pipe_vld  <= '0;
      total     <= '0;
      count     <= '0;
      proto_err <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        psum[k]      <= '0;
        pipe_data[k] <= '0;
        pipe_tag[k]  <= '0;
      end
    end else begin
      state     <= state_nxt;
      proto_err <= framing_bad;

      pipe_vld[0]  <= accept;
      pipe_data[0] <= in_data + operand_b;
      pipe_tag[0]  <= slot;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_data[k] <= pipe_data[k-1];
        pipe_tag[k]  <= pipe_tag[k-1];
      end
      if (pipe_vld[LAT-1]) psum[pipe_tag[LAT-1]] <= pipe_data[LAT-1];

      if (accept) begin
        ptr <= slot_nxt;
        if (row_start) begin
          used    <= '0;
          used[0] <= 1'b1;
          count   <= CNT_W'(1);
        end else begin
          used[slot] <= 1'b1;
          count      <= (count == '1) ? count : count + CNT_W'(1);
        end
      end

      if ((state == DRAIN) || (state == REDUCE)) begin
        phase <= phase_end ? '0 : phase + 4'd1;
      end else begin
        phase <= '0;
      end

      if ((state == DRAIN) && phase_end) begin
        total <= '0;
      end else if (state == REDUCE) begin
        total <= total + red_term;
      end
    end
  end

endmodule

// File: tb/tb_row_accum_ctrl.sv
// tb/tb_row_accum_ctrl.sv - directed bench for row_accum_ctrl with hand-computed sums
module tb_row_accum_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_count;
  logic        proto_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int perr_cnt = 0;
  int perr_base;

  row_accum_ctrl #(.DATA_W(24), .LAT(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .proto_err(proto_err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) if (proto_err) perr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one element for one cycle, then idles gap cycles.
  task automatic send(input logic [23:0] d, input logic f, input logic l, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    #2;
    check("in_ready_on_send", in_ready, 1);
    acc_cyc = cyc;
    @(negedge clock);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic expect_row(input string tag, input logic [23:0] sum, input logic [7:0] cnt,
                            input int hold);
    int n = 0;
    logic stable = 1'b1;
    while (!out_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_latency"}, cyc - acc_cyc, 9);
    check({tag, "_data"}, out_data, sum);
    check({tag, "_count"}, out_count, cnt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!out_valid || out_data !== sum || out_count !== cnt || in_ready) stable = 1'b0;
    end
    check({tag, "_stable"}, stable, 1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_proto_err", proto_err, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", in_ready, 1);

    // 1..10 back-to-back exercises the stage-LAT bypass on every slot reuse
    for (int i = 1; i <= 10; i++) send(24'(i), i == 1, i == 10, 0);
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    expect_row("row_1to10", 24'd55, 8'd10, 0);

    send(24'h000123, 1'b1, 1'b1, 0);
    check("single_in_ready", in_ready, 0);
    expect_row("single", 24'h000123, 8'd1, 0);

    // valid pattern 1,0,0,1,0,1,...
    send(24'd5, 1'b1, 1'b0, 2);
    send(24'd5, 1'b0, 1'b0, 1);
    send(24'd5, 1'b0, 1'b0, 2);
    send(24'd5, 1'b0, 1'b0, 1);
    send(24'd5, 1'b0, 1'b0, 2);
    send(24'd5, 1'b0, 1'b1, 0);
    expect_row("bubbles", 24'd30, 8'd6, 0);

    for (int i = 1; i <= 9; i++) send(24'(i * 3), i == 1, i == 9, i % 2);
    expect_row("mixed_gaps", 24'd135, 8'd9, 0);

    perr_base = perr_cnt;
    send(24'hFFFFFF, 1'b1, 1'b0, 0);
    send(24'hFFFFFF, 1'b0, 1'b0, 0);
    send(24'hFFFFFF, 1'b0, 1'b1, 0);
    expect_row("wrap", 24'hFFFFFD, 8'd3, 0);
    check("wrap_no_perr", perr_cnt - perr_base, 0);

    send(24'd10, 1'b1, 1'b0, 0);
    send(24'd20, 1'b0, 1'b0, 0);
    send(24'd30, 1'b0, 1'b1, 0);
    expect_row("backpressure", 24'd60, 8'd3, 5);
    send(24'd2, 1'b1, 1'b0, 0);
    send(24'd3, 1'b0, 1'b1, 0);
    expect_row("after_bp", 24'd5, 8'd2, 0);

    perr_base = perr_cnt;
    send(24'd7, 1'b0, 1'b0, 0);
    send(24'd1, 1'b0, 1'b1, 0);
    expect_row("no_first", 24'd8, 8'd2, 0);
    check("no_first_perr", perr_cnt - perr_base, 1);

    perr_base = perr_cnt;
    send(24'd1, 1'b1, 1'b0, 0);
    send(24'd2, 1'b1, 1'b0, 0);
    send(24'd3, 1'b0, 1'b1, 0);
    expect_row("first_mid_row", 24'd6, 8'd3, 0);
    check("first_mid_row_perr", perr_cnt - perr_base, 1);

    for (int i = 0; i < 300; i++) send(24'd1, i == 0, i == 299, 0);
    expect_row("saturate", 24'd300, 8'd255, 0);

    send(24'd7, 1'b1, 1'b0, 0);
    send(24'd8, 1'b0, 1'b0, 0);
    send(24'd9, 1'b0, 1'b0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("midrow_rst_busy", busy, 0);
    check("midrow_rst_valid", out_valid, 0);
    send(24'd7, 1'b1, 1'b0, 0);
    send(24'd8, 1'b0, 1'b1, 0);
    expect_row("after_reset", 24'd15, 8'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
